// File: rtl/ln_frame_sender_pkg.sv
// ln_frame_sender_pkg: constants and FSM encoding shared by the layer-norm stages and the frame sender.
package ln_frame_sender_pkg;
    localparam int DATA_W      = 16;
    localparam int T_STEPS     = 30;
    localparam int ADDR_W      = 5;
    localparam int SEL_W       = 3;
    localparam int TIMEOUT_CYC = 64;
    localparam int WD_W        = $clog2(TIMEOUT_CYC);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        FIN       = 2'd3
    } state_e;
endpackage

// File: rtl/ln_frame_buf.sv
// ln_frame_buf: T_STEPS x DATA_W frame store with one write port and one registered read port.
// Flags writes that are out of range or not allowed; a same-cycle write to the read address is forwarded.
module ln_frame_buf
    import ln_frame_sender_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_allow,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_rej
);
    logic [DATA_W-1:0] mem_q [T_STEPS];
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_hit;

    assign wr_hit = wr_en && wr_allow && (wr_addr < ADDR_W'(T_STEPS));
    assign wr_rej = wr_en && !wr_hit;

    always_ff @(posedge clk) begin
        if (wr_hit) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else if (rd_en) rd_data_q <= (wr_hit && wr_addr == rd_addr) ? wr_data : mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/ln_frame_sender.sv
// ln_frame_sender: streams a 30-frame spike buffer to the layer-norm stage, then waits for its done flag.
// Define LN_SEND_TIMEOUT_EN to add a WAIT_DONE watchdog and the sticky timeout_err output.
module ln_frame_sender
    import ln_frame_sender_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [SEL_W-1:0]  start_sel,
    input  logic              ln_done,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [SEL_W-1:0]  block_sel,
    output logic              busy,
    output logic              frame_done,
    output logic              wr_err
`ifdef LN_SEND_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(T_STEPS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              wr_err_q;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_rej;
    logic              wd_fire;

`ifdef LN_SEND_TIMEOUT_EN
    logic [WD_W-1:0] wd_q, wd_d;
    logic            tmo_q;

    assign wd_fire = (state_q == WAIT_DONE) && !ln_done && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign wd_d    = (state_q == WAIT_DONE) ? wd_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_q | wd_fire;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign wd_fire = 1'b0;
`endif

    // The frame read is issued one edge ahead, so frame 0 is fetched on the edge that samples start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    sel_d   = start_sel;
                    rd_en   = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q == LAST) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: state_d = (ln_done || wd_fire) ? FIN : WAIT_DONE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            wr_err_q <= wr_err_q | wr_rej;
        end
    end

    ln_frame_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_allow (state_q == IDLE),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (data_out),
        .wr_rej   (wr_rej)
    );

    assign data_out_valid = (state_q == SEND);
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == FIN);
    assign block_sel      = sel_q;
    assign wr_err         = wr_err_q;
endmodule

// File: tb/tb_ln_frame_sender.sv
// tb_ln_frame_sender: directed checks of the frame sender; cycle c = 0 is the cycle after start is sampled.
module tb_ln_frame_sender;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [2:0]  start_sel;
    logic        ln_done;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [2:0]  block_sel;
    logic        busy;
    logic        frame_done;
    logic        wr_err;
`ifdef LN_SEND_TIMEOUT_EN
    logic        timeout_err;
`endif

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q [30];

    ln_frame_sender dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .start          (start),
        .start_sel      (start_sel),
        .ln_done        (ln_done),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .block_sel      (block_sel),
        .busy           (busy),
        .frame_done     (frame_done),
        .wr_err         (wr_err)
`ifdef LN_SEND_TIMEOUT_EN
        ,
        .timeout_err    (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [2:0] sel);
        start     = 1'b1;
        start_sel = sel;
        tick();
        start     = 1'b0;
        start_sel = 3'd0;
    endtask

    task automatic test_reset;
        logic [15:0] one;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_sel = '0; ln_done = 1'b0;
        tick(); tick();
        tests++; if (data_out !== 16'h0) begin fails++; $display("FAIL reset data_out got %h exp 0000", data_out); end
        tests++; if ({data_out_valid, busy, frame_done, wr_err} !== 4'b0) begin fails++; $display("FAIL reset flags got %b exp 0000", {data_out_valid, busy, frame_done, wr_err}); end
        tests++; if (block_sel !== 3'd0) begin fails++; $display("FAIL reset block_sel got %0d exp 0", block_sel); end
        rst = 1'b0;
        tick();
        one = 16'h0001;
        for (int k = 0; k < 30; k++) begin
            exp_q[k] = one << (k % 16);
            wr_en = 1'b1; wr_addr = 5'(k); wr_data = exp_q[k];
            tick();
        end
        wr_en = 1'b0;
        tests++; if (wr_err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL load wr_err/busy got %b%b exp 00", wr_err, busy); end
    endtask

    task automatic test_stream;
        int nv = 0, fd_n = 0, fd_c = -1;
        ln_done = 1'b0;
        pulse_start(3'd3);
        for (int c = 0; c < 36; c++) begin
            tests++; if (data_out_valid !== (c < 30)) begin fails++; $display("FAIL stream valid c=%0d got %b exp %b", c, data_out_valid, c < 30); end
            if (data_out_valid && nv < 30) begin
                tests++; if (data_out !== exp_q[nv]) begin fails++; $display("FAIL stream data[%0d] got %h exp %h", nv, data_out, exp_q[nv]); end
                nv++;
            end
            tests++; if (block_sel !== 3'd3) begin fails++; $display("FAIL stream block_sel c=%0d got %0d exp 3", c, block_sel); end
            tests++; if (busy !== (c < 33)) begin fails++; $display("FAIL stream busy c=%0d got %b exp %b", c, busy, c < 33); end
            if (frame_done) begin fd_n++; fd_c = c; end
            if (c == 31) ln_done = 1'b1;
            tick();
        end
        ln_done = 1'b0;
        tests++; if (nv !== 30) begin fails++; $display("FAIL stream valid count got %0d exp 30", nv); end
        tests++; if (fd_n !== 1 || fd_c !== 32) begin fails++; $display("FAIL stream frame_done got n=%0d c=%0d exp n=1 c=32", fd_n, fd_c); end
    endtask

    task automatic test_same_cycle_write;
        int fd_n = 0;
        ln_done = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'h1234;
        start = 1'b1; start_sel = 3'd1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        exp_q[0] = 16'h1234;
        tests++; if (data_out !== 16'h1234 || data_out_valid !== 1'b1) begin fails++; $display("FAIL same-cycle frame0 got %h/%b exp 1234/1", data_out, data_out_valid); end
        tests++; if (block_sel !== 3'd1) begin fails++; $display("FAIL same-cycle block_sel got %0d exp 1", block_sel); end
        for (int c = 0; c < 34; c++) begin
            if (frame_done) fd_n++;
            tick();
        end
        tests++; if (fd_n !== 1 || busy !== 1'b0) begin fails++; $display("FAIL same-cycle completion got n=%0d busy=%b exp n=1 busy=0", fd_n, busy); end
        tests++; if (block_sel !== 3'd1) begin fails++; $display("FAIL same-cycle block_sel hold got %0d exp 1", block_sel); end
    endtask

    task automatic test_wr_err;
        tests++; if (wr_err !== 1'b0) begin fails++; $display("FAIL wr_err before got %b exp 0", wr_err); end
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        tests++; if (wr_err !== 1'b1) begin fails++; $display("FAIL wr_err addr31 got %b exp 1", wr_err); end
        ln_done = 1'b1;
        for (int run = 0; run < 2; run++) begin
            int nv = 0, fd_n = 0;
            pulse_start(3'd3);
            for (int c = 0; c < 34; c++) begin
                if (data_out_valid && nv < 30) begin
                    if (nv == 5) begin
                        tests++; if (data_out !== exp_q[5]) begin fails++; $display("FAIL wr_err run%0d frame5 got %h exp %h", run, data_out, exp_q[5]); end
                    end
                    nv++;
                end
                if (frame_done) fd_n++;
                wr_en = (run == 0 && c == 4); wr_addr = 5'd5; wr_data = 16'hBEEF;
                tick();
            end
            wr_en = 1'b0;
            tests++; if (nv !== 30 || fd_n !== 1) begin fails++; $display("FAIL wr_err run%0d got nv=%0d fd=%0d exp nv=30 fd=1", run, nv, fd_n); end
            tests++; if (wr_err !== 1'b1) begin fails++; $display("FAIL wr_err sticky run%0d got %b exp 1", run, wr_err); end
        end
    endtask

    task automatic test_restart_ignored;
        int nv = 0;
        ln_done = 1'b1;
        pulse_start(3'd3);
        for (int c = 0; c < 36; c++) begin
            if (data_out_valid) begin
                if (nv < 30) begin
                    tests++; if (data_out !== exp_q[nv]) begin fails++; $display("FAIL restart data[%0d] got %h exp %h", nv, data_out, exp_q[nv]); end
                end
                nv++;
            end
            tests++; if (block_sel !== 3'd3) begin fails++; $display("FAIL restart block_sel c=%0d got %0d exp 3", c, block_sel); end
            start = (c == 9); start_sel = (c == 9) ? 3'd6 : 3'd0;
            tick();
        end
        start = 1'b0;
        tests++; if (nv !== 30) begin fails++; $display("FAIL restart valid count got %0d exp 30", nv); end
    endtask

    task automatic test_sticky_done;
        ln_done = 1'b1;
        for (int run = 0; run < 2; run++) begin
            int fd_n = 0, fd_c = -1, last_v = -1;
            pulse_start(3'd2);
            for (int c = 0; c < 36; c++) begin
                if (data_out_valid) last_v = c;
                if (frame_done) begin fd_n++; fd_c = c; end
                tick();
            end
            tests++; if (last_v !== 29 || fd_n !== 1 || fd_c !== 31) begin fails++; $display("FAIL sticky run%0d got last=%0d n=%0d fd=%0d exp 29 1 31", run, last_v, fd_n, fd_c); end
        end
    endtask

    task automatic test_reset_abort;
        int nv = 0, fd_n = 0, fd_c = -1;
        ln_done = 1'b1;
        pulse_start(3'd3);
        for (int c = 0; c < 14; c++) tick();
        tests++; if (data_out_valid !== 1'b1 || data_out !== exp_q[14]) begin fails++; $display("FAIL abort pre frame14 got %h/%b exp %h/1", data_out, data_out_valid, exp_q[14]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if ({data_out_valid, busy, frame_done, wr_err} !== 4'b0 || data_out !== 16'h0 || block_sel !== 3'd0) begin fails++; $display("FAIL abort outputs got %h %b%b%b%b sel=%0d exp 0", data_out, data_out_valid, busy, frame_done, wr_err, block_sel); end
        for (int c = 0; c < 6; c++) begin
            if (data_out_valid || frame_done) fd_n++;
            tick();
        end
        tests++; if (fd_n !== 0) begin fails++; $display("FAIL abort quiet got %0d events exp 0", fd_n); end
        fd_n = 0;
        pulse_start(3'd5);
        for (int c = 0; c < 36; c++) begin
            if (data_out_valid && nv < 30) begin
                tests++; if (data_out !== exp_q[nv]) begin fails++; $display("FAIL abort rerun data[%0d] got %h exp %h", nv, data_out, exp_q[nv]); end
                nv++;
            end
            if (frame_done) begin fd_n++; fd_c = c; end
            tick();
        end
        tests++; if (nv !== 30 || fd_n !== 1 || fd_c !== 31) begin fails++; $display("FAIL abort rerun got nv=%0d n=%0d fd=%0d exp 30 1 31", nv, fd_n, fd_c); end
    endtask

`ifdef LN_SEND_TIMEOUT_EN
    task automatic test_timeout;
        int fd_n = 0, fd_c = -1;
        ln_done = 1'b0;
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout initial got %b exp 0", timeout_err); end
        pulse_start(3'd4);
        for (int c = 0; c < 100; c++) begin
            tests++; if (timeout_err !== (c >= 94)) begin fails++; $display("FAIL timeout_err c=%0d got %b exp %b", c, timeout_err, c >= 94); end
            if (frame_done) begin fd_n++; fd_c = c; end
            tick();
        end
        tests++; if (fd_n !== 1 || fd_c !== 94) begin fails++; $display("FAIL timeout frame_done got n=%0d c=%0d exp 1 94", fd_n, fd_c); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_same_cycle_write();
        test_wr_err();
        test_restart_ignored();
        test_sticky_done();
        test_reset_abort();
`ifdef LN_SEND_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
